instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encoder/loader for the single-cycle core's instruction memory; the encoding counterpart of the control decoder.
- Accepts symbolic instructions (mnemonic code plus fields) over a valid/ready handshake and encodes each into a 32-bit word using the core's opcode/func map.
- Writes words sequentially into instruction memory from a base address.
- Used by the boot/test path to load programs before the core is released from reset.

Parameters:
AW, 8, instruction memory word-address width
BASE_ADDR, 0, first word address written after start
DEPTH, 256, number of writable words; last writable address is BASE_ADDR+DEPTH-1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; arms a load session
inValid  input  1  instruction fields valid
inReady  output  1  encoder can accept an instruction this cycle
instCode  input  4  0 add, 1 sub, 2 or, 3 xor, 4 and, 5 sltu, 6 slt, 7 jr, 8 addi, 9 sw, 10 lw, 11 beq, 12 bneq, 13 j, 14 halt, 15 illegal
rs  input  5  source register
rt  input  5  second source / I-type destination
rd  input  5  R-type destination
imm  input  16  I-type immediate / branch offset
tgt  input  26  jump target
imWrite  output  1  instruction memory write strobe
imAddr  output  AW  instruction memory write address
imData  output  32  encoded word
busy  output  1  session in progress (state LOAD)
done  output  1  session finished; held until next start
illErr  output  1  illegal code received; sticky per session
ovfErr  output  1  memory filled without halt; sticky per session
wordCount  output  AW+1  words written this session

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset: every output 0 except inReady=0; state IDLE; address register = BASE_ADDR. Reset mid-session drops any pending write (imWrite=0 next cycle) and discards the session.
- States: IDLE, LOAD, DONE.
- IDLE: inReady=0, busy=0. On start, go to LOAD; clear addr to BASE_ADDR, and clear wordCount, done, illErr and ovfErr.
- LOAD: inReady=1 (combinational from state); busy=1. start is ignored.
- Acceptance occurs in cycle t when inValid & inReady. At t+1:
  - imWrite=1, imAddr=addr, imData=encoded word.
  - addr increments; wordCount increments.
  - imWrite is 0 in any cycle not following an acceptance.
- Throughput: one instruction per cycle, back-to-back.
- Encoding, field positions [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] 0, [5:0] func:
  - codes 0-6 (add..slt): op 100000, func = code (000000..000110), rs/rt/rd from inputs.
  - code 7 (jr): op 100000, func 000111, rs from input, rt=rd=0.
  - codes 8-12 (I-type): op addi 000000, sw 000001, lw 000010, beq 010001, bneq 010000; rs, rt and imm from inputs; rd ignored.
  - code 13 (j): op 010010, [25:0]=tgt.
  - code 14 (halt): op 111111, [25:0]=0.
- Fields irrelevant to a format are forced to 0, regardless of input values.
- Halt accepted: halt word is written at t+1; state DONE at t+1, so inReady=0 at t+1.
- Illegal code (15) accepted: no write; illErr=1 at t+1; state DONE at t+1.
- Full: a non-halt accepted at addr = BASE_ADDR+DEPTH-1 is written, then ovfErr=1 and state DONE at t+1. Address never wraps.
- Halt accepted at the last address: written, ovfErr stays 0.
- DONE: done=1, busy=0, inReady=0; errors and wordCount held. start returns to LOAD and re-initialises as from IDLE.
- start and reset asserted in the same cycle: reset wins.

Test Plan:
- Reset check: assert reset 2 cycles with inValid=1 and start=1 -> imWrite=0, inReady=0, busy=0, done=0, wordCount=0.
- R-type and jr: start; add rs=1 rt=2 rd=3 -> imData 0x80221800 at imAddr 0; then jr rs=31 back-to-back -> 0x83E00007 at imAddr 1 on the next cycle, wordCount=2.
- I-type and j: addi rt=5 rs=0 imm=7 -> 0x00050007; sw rs=1 rt=4 imm=8 -> 0x04240008; beq rs=1 rt=2 imm=0xFFFE with rd=31 -> 0x4422FFFE; j tgt=0x10 -> 0x48000010.
- Halt: halt with nonzero rs/imm -> 0xFC000000 written; done=1 the next cycle, inReady=0; further inValid produces no writes. A new start -> busy=1, wordCount=0, first write again at BASE_ADDR.
- Illegal: code 15 mid-stream -> no write that cycle, illErr=1, done=1; wordCount equals the writes before the illegal code.
- Overflow: DEPTH=4, feed 5 add instructions continuously -> exactly 4 writes at addresses 0-3, ovfErr=1 and done=1 after the 4th; inReady=0 for the 5th. Repeat with halt as the 4th instruction -> ovfErr=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Instruction-in handshake plus instruction-memory write bus for instr_encoder.
// master drives symbolic instructions and observes the memory writes; slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned AW = 8
) ();
  logic          inValid;
  logic          inReady;
  logic [3:0]    instCode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic [25:0]   tgt;
  logic          imWrite;
  logic [AW-1:0] imAddr;
  logic [31:0]   imData;

  modport master (
    output inValid, instCode, rs, rt, rd, imm, tgt,
    input  inReady, imWrite, imAddr, imData
  );

  modport slave (
    input  inValid, instCode, rs, rt, rd, imm, tgt,
    output inReady, imWrite, imAddr, imData
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic instructions into 32-bit core words and writes them
// sequentially into instruction memory from BASE_ADDR during a load session.
module instr_encoder #(
  parameter int unsigned AW        = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           illErr,
  output logic           ovfErr,
  output logic [AW:0]    wordCount
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);
  localparam logic [AW-1:0] LAST_A = AW'(BASE_ADDR + DEPTH - 1);

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b000000;
  localparam logic [5:0] OP_SW   = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b010001;
  localparam logic [5:0] OP_BNEQ = 6'b010000;
  localparam logic [5:0] OP_J    = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] FN_JR   = 6'b000111;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   wc_q, wc_d;
  logic          ill_q, ill_d;
  logic          ovf_q, ovf_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          accept;
  logic          start_sess;
  logic          is_halt;
  logic          is_ill;
  logic          at_last;
  logic [31:0]   enc;

  assign accept     = bus.inValid & (state_q == LOAD);
  assign start_sess = start & (state_q != LOAD);
  assign is_halt    = (bus.instCode == 4'd14);
  assign is_ill     = (bus.instCode == 4'd15);
  assign at_last    = (addr_q == LAST_A);

  always_comb begin
    enc = '0;
    case (bus.instCode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
        enc = {OP_R, bus.rs, bus.rt, bus.rd, 5'd0, 2'b00, bus.instCode};
      4'd7:    enc = {OP_R, bus.rs, 15'd0, FN_JR};
      4'd8:    enc = {OP_ADDI, bus.rs, bus.rt, bus.imm};
      4'd9:    enc = {OP_SW,   bus.rs, bus.rt, bus.imm};
      4'd10:   enc = {OP_LW,   bus.rs, bus.rt, bus.imm};
      4'd11:   enc = {OP_BEQ,  bus.rs, bus.rt, bus.imm};
      4'd12:   enc = {OP_BNEQ, bus.rs, bus.rt, bus.imm};
      4'd13:   enc = {OP_J, bus.tgt};
      4'd14:   enc = {OP_HALT, 26'd0};
      default: enc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && (is_ill || is_halt || at_last)) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.inReady = (state_q == LOAD);
    busy        = (state_q == LOAD);
    done        = (state_q == DONE);
  end

  always_comb begin
    addr_d  = addr_q;
    wc_d    = wc_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (start_sess) begin
      addr_d = BASE_A;
      wc_d   = '0;
      ill_d  = 1'b0;
      ovf_d  = 1'b0;
    end else if (accept) begin
      if (is_ill) begin
        ill_d = 1'b1;
      end else begin
        wr_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = enc;
        wc_d    = wc_q + 1'b1;
        // Address parks on the last word instead of wrapping; the session ends there.
        if (at_last) ovf_d  = ~is_halt;
        else         addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= BASE_A;
      wc_q    <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imWrite = wr_q;
  assign bus.imAddr  = waddr_q;
  assign bus.imData  = wdata_q;
  assign illErr      = ill_q;
  assign ovfErr      = ovf_q;
  assign wordCount   = wc_q;

endmodule
